inst_encoder_loader: RTL and testbench
======================================

// Module: inst_encoder_loader
// PURPOSE
//  Inverse of the WISC-16 instruction decoder: takes per-instruction field descriptors
//  (opcode, func, rs/rt/rd, immediate/displacement) over a valid/ready stream, packs each
//  into a 16-bit instruction word and writes it to consecutive instruction-memory addresses.
//  Sits between the test/boot program source and the instruction memory write port.
//  A batch is started with a base address and a length, and ends with a one-cycle done pulse.
// PARAMETERS
//  ADDR_W    16  instruction memory address width
//  ADDR_STEP 2   address increment per word (memory is byte-addressed)
//  LEN_W     8   width of batch length / index
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin batch; sampled in IDLE only
//  base_addr  in   ADDR_W address of first word, captured on start
//  length     in   LEN_W  number of descriptors in batch, captured on start
//  in_valid   in   1      descriptor valid
//  in_ready   out  1      descriptor accepted when in_valid && in_ready
//  in_opcode  in   5      inst[15:11]
//  in_func    in   2      R-format function, inst[1:0]
//  in_rs/in_rt/in_rd in 3 register fields
//  in_imm     in   16     immediate or jump displacement (two's complement or unsigned per format)
//  mem_wr     out  1      write strobe
//  mem_addr   out  ADDR_W write address
//  mem_data   out  16     encoded instruction
//  mem_stall  in   1      memory not accepting; write completes on mem_wr && !mem_stall
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse at end of batch
//  err        out  1      sticky range error (cleared on start)
//  err_idx    out  LEN_W  index of the first descriptor that failed
// BEHAVIOUR
//  Encoding (op = in_opcode):
//   010xx,101xx,100xx except 10010: {op,rs,rd,imm[4:0]}; op 0101x is unsigned 0..31, others signed -16..15
//   10010: {op,rs,imm[7:0]}, unsigned 0..255 | 011xx: {op,rs,imm[7:0]}, signed -128..127
//   110xx,111xx: {op,rs,rt,rd,func} | 001x0: {op,imm[10:0]}, signed -1024..1023
//   001x1: {op,rs,imm[7:0]}, signed -128..127 | 000xx: {op,11'b0}
//  FSM: IDLE -> RUN (start, length!=0) | IDLE -> DONE (start, length==0)
//   RUN -> DONE after last write completes | RUN -> ABORT on range error
//   ABORT -> DONE once the output register has drained
//   DONE -> IDLE after one cycle; done=1 only in DONE
//  Output register (1 entry): holds data and address.
//   in_ready = (state==RUN) && (accepted<length) && (!mem_wr || !mem_stall)
//  Latency: descriptor accepted in cycle N -> mem_wr=1 in cycle N+1. Full throughput of 1 word/cycle while !mem_stall.
//  mem_wr, mem_addr and mem_data are held stable while mem_stall is high.
//  Address: word k is written to base_addr + k*ADDR_STEP, wrapping modulo 2**ADDR_W.
//  start is ignored in every state except IDLE. The batch ends only after the last write has completed.
//  Reset: state=IDLE; in_ready, mem_wr, busy, done and err are 0; mem_addr, mem_data and err_idx are 0.
//   Reset asserted mid-batch drops mem_wr immediately; the partial batch is lost.
// CONFIGURATION
//  ENC_RANGE_CHECK_EN defined:
//   A descriptor whose in_imm is not representable in its field is consumed but not written.
//   err=1 and err_idx=its index; FSM goes to ABORT and accepts no further descriptors.
//  ENC_RANGE_CHECK_EN undefined:
//   in_imm is silently truncated to the field width; err and err_idx are tied to 0.
// STRUCTURE
//  Package wisc_isa_pkg: opcode-class constants, field positions and widths, FSM state enum.
//  Sub-module inst_field_encoder: combinational encoder that outputs the word and a range_err flag.
//  Top level: FSM, accept/write counters, address adder, output register.
// TESTING
//  1 base=0x0000 len=1, op=01000 rs=1 rd=2 imm=-1 -> next cycle mem_wr, addr 0x0000, data 0x415F; done pulse
//  2 op=11011 rs=3 rt=4 rd=5 func=2 -> data 0xDB96; op=10010 rs=7 imm=0x00FF -> data 0x97FF
//  3 op=00100 imm=-2 -> data 0x27FE; op=00000 with nonzero fields -> data 0x0000
//  4 base=0x0010 len=3, mem_stall=1 for 2 cycles on first write -> in_ready low while stalled; addr 0x0010/12/14; single done pulse
//  5 base=0xFFFE len=2 -> writes to 0xFFFE then 0x0000; len=0 -> done in the cycle after start, no mem_wr
//  6 op=01000 imm=16 as idx 1 of 3 -> macro on: err=1, err_idx=1, one write, done; macro off: data imm5=10000, 3 writes

Source files
------------

// File: rtl/wisc_isa_pkg.sv
// rtl/wisc_isa_pkg.sv - WISC-16 field widths, opcode classes, loader FSM states and range helpers
package wisc_isa_pkg;

  localparam int INST_W  = 16;
  localparam int OP_W    = 5;
  localparam int REG_W   = 3;
  localparam int FUNC_W  = 2;
  localparam int IMM5_W  = 5;
  localparam int IMM8_W  = 8;
  localparam int IMM11_W = 11;

  // The only 100xx opcode that carries an 8-bit unsigned immediate instead of rd/imm5
  localparam logic [OP_W-1:0] OP_SLBI = 5'b10010;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // True when imm, read as two's complement, survives truncation to w bits
  function automatic logic fits_signed(input logic [15:0] imm, input int w);
    logic [15:0] t;
    t = 16'($signed(imm) >>> (w - 1));
    return (t == 16'h0000) || (t == 16'hFFFF);
  endfunction

  // True when imm, read as unsigned, survives truncation to w bits
  function automatic logic fits_unsigned(input logic [15:0] imm, input int w);
    return (imm >> w) == 16'h0000;
  endfunction

endpackage

// File: rtl/inst_field_encoder.sv
// rtl/inst_field_encoder.sv - combinational WISC-16 field packer with immediate range flag
module inst_field_encoder
  import wisc_isa_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [15:0]       imm,
  output logic [INST_W-1:0] word,
  output logic              range_err
);

  // Pack fields by opcode class; casez order matters because SLBI shadows the 10xxx class
  always_comb begin
    word      = '0;
    range_err = 1'b0;
    casez (opcode)
      5'b000??: word = {opcode, 11'b0};
      5'b001?0: begin
        word      = {opcode, imm[10:0]};
        range_err = !fits_signed(imm, IMM11_W);
      end
      5'b001?1, 5'b011??: begin
        word      = {opcode, rs, imm[7:0]};
        range_err = !fits_signed(imm, IMM8_W);
      end
      OP_SLBI: begin
        word      = {opcode, rs, imm[7:0]};
        range_err = !fits_unsigned(imm, IMM8_W);
      end
      5'b0101?: begin
        word      = {opcode, rs, rd, imm[4:0]};
        range_err = !fits_unsigned(imm, IMM5_W);
      end
      5'b0100?, 5'b10???: begin
        word      = {opcode, rs, rd, imm[4:0]};
        range_err = !fits_signed(imm, IMM5_W);
      end
      default: word = {opcode, rs, rt, rd, func};
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - descriptor-to-instruction loader; ENC_RANGE_CHECK_EN enables range abort
module inst_encoder_loader
  import wisc_isa_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 2,
  parameter int LEN_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [1:0]        in_func,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  err_idx
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, acc_q, acc_d, err_idx_q, err_idx_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, mem_addr_q, mem_addr_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic              mem_wr_q, mem_wr_d, err_q, err_d;

  logic [15:0] enc_word;
  logic        enc_range_err;
  logic        bad, accept, wr_done, drained, all_accepted;

  inst_field_encoder u_enc (
    .opcode    (in_opcode),
    .func      (in_func),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .imm       (in_imm),
    .word      (enc_word),
    .range_err (enc_range_err)
  );

`ifdef ENC_RANGE_CHECK_EN
  assign bad = enc_range_err;
`else
  // Out-of-range immediates are simply truncated by the packer
  logic unused_range_err;
  assign unused_range_err = enc_range_err;
  assign bad = 1'b0;
`endif

  assign wr_done      = mem_wr_q && !mem_stall;
  assign drained      = !mem_wr_q || wr_done;
  assign all_accepted = (acc_q == len_q);
  assign in_ready     = (state_q == ST_RUN) && (acc_q < len_q) && drained;
  assign accept       = in_valid && in_ready;

  // Next-state: batch FSM, accept counter, address walker and the single output register
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    next_addr_d = next_addr_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    if (wr_done) mem_wr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = length;
          acc_d       = '0;
          next_addr_d = base_addr;
          err_d       = 1'b0;
          err_idx_d   = '0;
          state_d     = (length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_d = acc_q + LEN_W'(1);
          if (bad) begin
            err_d     = 1'b1;
            err_idx_d = acc_q;
            state_d   = ST_ABORT;
          end else begin
            mem_wr_d    = 1'b1;
            mem_addr_d  = next_addr_q;
            mem_data_d  = enc_word;
            next_addr_d = next_addr_q + STEP;
          end
        end else if (all_accepted && drained) begin
          state_d = ST_DONE;
        end
      end
      ST_ABORT: if (drained) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight write immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      next_addr_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      err_q       <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      next_addr_q <= next_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - directed self-checking bench for inst_encoder_loader
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  length = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [1:0]  in_func = '0;
  logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic        mem_wr;
  logic [15:0] mem_addr, mem_data;
  logic        mem_stall = 1'b0;
  logic        busy, done, err;
  logic [7:0]  err_idx;

  inst_encoder_loader #(.ADDR_W(16), .ADDR_STEP(2), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_func(in_func),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data), .mem_stall(mem_stall),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [4:0]  d_op[8];
  logic [1:0]  d_func[8];
  logic [2:0]  d_rs[8], d_rt[8], d_rd[8];
  logic [15:0] d_imm[8];

  logic [15:0] wr_addr[64], wr_data[64];
  int wr_n = 0;
  int done_n = 0;

  // Write/done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && mem_wr && !mem_stall) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] <= mem_addr;
        wr_data[wr_n] <= mem_data;
      end
      wr_n <= wr_n + 1;
    end
    if (rst_n && done) done_n <= done_n + 1;
  end

  task automatic set_desc(input int i, input logic [4:0] op, input logic [1:0] fn,
                          input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                          input logic [15:0] imm);
    d_op[i] = op; d_func[i] = fn; d_rs[i] = rs; d_rt[i] = rt; d_rd[i] = rd; d_imm[i] = imm;
  endtask

  task automatic drive_desc(input int i);
    in_opcode = d_op[i]; in_func = d_func[i]; in_rs = d_rs[i];
    in_rt = d_rt[i]; in_rd = d_rd[i]; in_imm = d_imm[i];
  endtask

  task automatic start_batch(input logic [15:0] b, input logic [7:0] l);
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_accept(input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!got) begin
      n_checks++;
      $display("FAIL %s_accept_timeout: in_ready=0 for 100 cycles, required 1", tag);
    end
  endtask

  task automatic feed(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      drive_desc(i);
      in_valid = 1'b1;
      wait_accept(tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!got) begin
      n_checks++;
      $display("FAIL %s_done_timeout: done=0 for 100 cycles, required 1", tag);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr: got %b want 0", mem_wr); else n_pass++;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL rst_busy_done_err: got %b want 000", {busy, done, err}); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0 || mem_data !== 16'h0) $display("FAIL rst_addr_data: got %h/%h want 0000/0000", mem_addr, mem_data); else n_pass++;
    n_checks++; if (err_idx !== 8'h0) $display("FAIL rst_err_idx: got %h want 00", err_idx); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int wb, db;
    set_desc(0, 5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 16'hFFFF);
    wb = wr_n; db = done_n;
    start_batch(16'h0000, 8'd1);
    drive_desc(0); in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b1) $display("FAIL single_latency_wr: got %b want 1", mem_wr); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL single_addr: got %h want 0000", mem_addr); else n_pass++;
    n_checks++; if (mem_data !== 16'h415F) $display("FAIL single_data: got %h want 415F", mem_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL single_ready_after_last: got %b want 0", in_ready); else n_pass++;
    wait_done("single");
    repeat (2) @(posedge clk); #1;
    n_checks++; if (done_n - db !== 1) $display("FAIL single_done_pulses: got %0d want 1", done_n - db); else n_pass++;
    n_checks++; if (wr_n - wb !== 1) $display("FAIL single_writes: got %0d want 1", wr_n - wb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_encodings();
    int wb;
    logic [15:0] ed[4];
    logic [15:0] ea[4];
    ed = '{16'hDB96, 16'h97FF, 16'h27FE, 16'h0000};
    ea = '{16'h0020, 16'h0022, 16'h0024, 16'h0026};
    set_desc(0, 5'b11011, 2'd2, 3'd3, 3'd4, 3'd5, 16'h0000);
    set_desc(1, 5'b10010, 2'd0, 3'd7, 3'd0, 3'd0, 16'h00FF);
    set_desc(2, 5'b00100, 2'd0, 3'd5, 3'd0, 3'd0, 16'hFFFE);
    set_desc(3, 5'b00000, 2'd3, 3'd7, 3'd7, 3'd7, 16'h1234);
    wb = wr_n;
    start_batch(16'h0020, 8'd4);
    feed(0, 3, "enc");
    wait_done("enc");
    n_checks++; if (wr_n - wb !== 4) $display("FAIL enc_writes: got %0d want 4", wr_n - wb); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_data[wb + k] !== ed[k]) $display("FAIL enc_data%0d: got %h want %h", k, wr_data[wb + k], ed[k]); else n_pass++;
      n_checks++;
      if (wr_addr[wb + k] !== ea[k]) $display("FAIL enc_addr%0d: got %h want %h", k, wr_addr[wb + k], ea[k]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int wb, db;
    logic [15:0] ed[3];
    logic [15:0] ea[3];
    ed = '{16'hE14D, 16'h2C7F, 16'hA630};
    ea = '{16'h0010, 16'h0012, 16'h0014};
    set_desc(0, 5'b11100, 2'd1, 3'd1, 3'd2, 3'd3, 16'h0000);
    set_desc(1, 5'b00101, 2'd0, 3'd4, 3'd0, 3'd0, 16'h007F);
    set_desc(2, 5'b10100, 2'd0, 3'd6, 3'd0, 3'd1, 16'hFFF0);
    wb = wr_n; db = done_n;
    start_batch(16'h0010, 8'd3);
    drive_desc(0); in_valid = 1'b1;
    wait_accept("stall");
    mem_stall = 1'b1;
    drive_desc(1);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", s, in_ready); else n_pass++;
      n_checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h0010 || mem_data !== 16'hE14D)
        $display("FAIL stall_hold%0d: got wr=%b addr=%h data=%h want 1/0010/E14D", s, mem_wr, mem_addr, mem_data);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    feed(1, 2, "stall");
    wait_done("stall");
    repeat (2) @(posedge clk); #1;
    n_checks++; if (wr_n - wb !== 3) $display("FAIL stall_writes: got %0d want 3", wr_n - wb); else n_pass++;
    n_checks++; if (done_n - db !== 1) $display("FAIL stall_done_pulses: got %0d want 1", done_n - db); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wr_addr[wb + k] !== ea[k] || wr_data[wb + k] !== ed[k])
        $display("FAIL stall_word%0d: got %h@%h want %h@%h", k, wr_data[wb + k], wr_addr[wb + k], ed[k], ea[k]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int wb;
    set_desc(0, 5'b01010, 2'd0, 3'd0, 3'd0, 3'd0, 16'h001F);
    set_desc(1, 5'b01100, 2'd0, 3'd2, 3'd0, 3'd0, 16'hFF80);
    wb = wr_n;
    start_batch(16'hFFFE, 8'd2);
    feed(0, 1, "wrap");
    wait_done("wrap");
    n_checks++; if (wr_n - wb !== 2) $display("FAIL wrap_writes: got %0d want 2", wr_n - wb); else n_pass++;
    n_checks++; if (wr_addr[wb] !== 16'hFFFE || wr_data[wb] !== 16'h501F)
      $display("FAIL wrap_word0: got %h@%h want 501F@FFFE", wr_data[wb], wr_addr[wb]); else n_pass++;
    n_checks++; if (wr_addr[wb + 1] !== 16'h0000 || wr_data[wb + 1] !== 16'h6280)
      $display("FAIL wrap_word1: got %h@%h want 6280@0000", wr_data[wb + 1], wr_addr[wb + 1]); else n_pass++;
  endtask

  task automatic test_empty();
    int wb;
    wb = wr_n;
    start_batch(16'h1234, 8'd0);
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL empty_done: got %b want 1", done); else n_pass++;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL empty_wr: got %b want 0", mem_wr); else n_pass++;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (wr_n !== wb) $display("FAIL empty_writes: got %0d want %0d", wr_n, wb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL empty_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mid_reset();
    set_desc(0, 5'b11000, 2'd0, 3'd1, 3'd1, 3'd1, 16'h0000);
    start_batch(16'h0040, 8'd2);
    drive_desc(0); in_valid = 1'b1;
    wait_accept("midrst");
    n_checks++; if (mem_wr !== 1'b1) $display("FAIL midrst_pre_wr: got %b want 1", mem_wr); else n_pass++;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL midrst_wr_drop: got %b want 0", mem_wr); else n_pass++;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL midrst_idle: got busy=%b rdy=%b want 0/0", busy, in_ready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_range();
    int wb;
    set_desc(0, 5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 16'h0003);
    set_desc(1, 5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 16'h0010);
    set_desc(2, 5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 16'h0001);
    wb = wr_n;
    start_batch(16'h0100, 8'd3);
`ifdef ENC_RANGE_CHECK_EN
    feed(0, 1, "range");
    drive_desc(2); in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL range_ready_after_err: got %b want 0", in_ready); else n_pass++;
    wait_done("range");
    in_valid = 1'b0;
    n_checks++; if (err !== 1'b1) $display("FAIL range_err: got %b want 1", err); else n_pass++;
    n_checks++; if (err_idx !== 8'd1) $display("FAIL range_err_idx: got %0d want 1", err_idx); else n_pass++;
    n_checks++; if (wr_n - wb !== 1) $display("FAIL range_writes: got %0d want 1", wr_n - wb); else n_pass++;
    n_checks++; if (wr_data[wb] !== 16'h4143 || wr_addr[wb] !== 16'h0100)
      $display("FAIL range_word0: got %h@%h want 4143@0100", wr_data[wb], wr_addr[wb]); else n_pass++;
    start_batch(16'h0000, 8'd0);
    @(negedge clk);
    n_checks++; if (err !== 1'b0) $display("FAIL range_err_clear: got %b want 0", err); else n_pass++;
    @(posedge clk); #1;
`else
    feed(0, 2, "range");
    wait_done("range");
    n_checks++; if (wr_n - wb !== 3) $display("FAIL range_writes: got %0d want 3", wr_n - wb); else n_pass++;
    n_checks++; if (wr_data[wb + 1] !== 16'h4150 || wr_addr[wb + 1] !== 16'h0102)
      $display("FAIL range_trunc_word: got %h@%h want 4150@0102", wr_data[wb + 1], wr_addr[wb + 1]); else n_pass++;
    n_checks++; if (wr_data[wb + 2] !== 16'h4141 || wr_addr[wb + 2] !== 16'h0104)
      $display("FAIL range_word2: got %h@%h want 4141@0104", wr_data[wb + 2], wr_addr[wb + 2]); else n_pass++;
    n_checks++; if (err !== 1'b0 || err_idx !== 8'd0) $display("FAIL range_err_tied: got %b/%0d want 0/0", err, err_idx); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_encodings();
    test_stall();
    test_wrap();
    test_empty();
    test_mid_reset();
    test_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
